// File: rtl/e1_tdm_mux.sv
// E1 TDM multiplexer: NCH per-channel byte FIFOs served round-robin, one slot per clock.
// Optional sticky overflow status (ovfclr/ovfsta) is built when E1_TDM_MUX_OVF_STAT_EN is defined.
module e1_tdm_mux #(
    parameter int WID   = 8,
    parameter int NCH   = 21,
    parameter int CHB   = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NCH*WID-1:0] di,
    input  logic [NCH-1:0]     vld,
`ifdef E1_TDM_MUX_OVF_STAT_EN
    input  logic [NCH-1:0]     ovfclr,
    output logic [NCH-1:0]     ovfsta,
`endif
    output logic [CHB-1:0]     oid,
    output logic [WID-1:0]     dout,
    output logic               dovld,
    output logic [NCH-1:0]     full,
    output logic [NCH-1:0]     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CHB-1:0] chcnt_q, chcnt_d;
    logic [PW-1:0]  wptr_q [NCH];
    logic [PW-1:0]  wptr_d [NCH];
    logic [PW-1:0]  rptr_q [NCH];
    logic [PW-1:0]  rptr_d [NCH];
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [WID-1:0] mem_q  [NCH][DEPTH];

    logic [NCH-1:0] push_s;
    logic [NCH-1:0] pop_s;
    logic [NCH-1:0] full_q, full_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [CHB-1:0] oid_q, oid_d;
    logic [WID-1:0] dout_q, dout_d;
    logic [WID-1:0] rdata_s;
    logic           dovld_q, dovld_d;

    // Per-channel push/pop decisions; pop uses the pre-push count so a byte never bypasses its FIFO.
    always_comb begin
        push_s  = '0;
        pop_s   = '0;
        ovf_d   = '0;
        full_d  = '0;
        rdata_s = '0;
        for (int c = 0; c < NCH; c++) begin
            wptr_d[c] = wptr_q[c];
            rptr_d[c] = rptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if ((chcnt_q == CHB'(c)) && (cnt_q[c] != '0)) begin
                pop_s[c] = 1'b1;
                rdata_s  = mem_q[c][rptr_q[c]];
            end else begin
                pop_s[c] = 1'b0;
            end
            if (vld[c] && ((cnt_q[c] != CW'(DEPTH)) || pop_s[c])) begin
                push_s[c] = 1'b1;
            end else begin
                push_s[c] = 1'b0;
            end
            ovf_d[c] = vld[c] & ~push_s[c];
            if (push_s[c]) begin
                wptr_d[c] = wptr_q[c] + PW'(1);
            end else begin
                wptr_d[c] = wptr_q[c];
            end
            if (pop_s[c]) begin
                rptr_d[c] = rptr_q[c] + PW'(1);
            end else begin
                rptr_d[c] = rptr_q[c];
            end
            case ({push_s[c], pop_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
            full_d[c] = (cnt_d[c] == CW'(DEPTH));
        end
    end

    // Slot counter and registered slot result; dout holds its last byte on idle slots.
    always_comb begin
        if (chcnt_q == CHB'(NCH - 1)) begin
            chcnt_d = '0;
        end else begin
            chcnt_d = chcnt_q + CHB'(1);
        end
        oid_d   = chcnt_q;
        dovld_d = |pop_s;
        if (|pop_s) begin
            dout_d = rdata_s;
        end else begin
            dout_d = dout_q;
        end
    end

    // FIFO storage carries no reset; unread entries are never observable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push_s[c]) begin
                mem_q[c][wptr_q[c]] <= di[c*WID +: WID];
            end
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chcnt_q <= '0;
            oid_q   <= '0;
            dout_q  <= '0;
            dovld_q <= 1'b0;
            full_q  <= '0;
            ovf_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            chcnt_q <= chcnt_d;
            oid_q   <= oid_d;
            dout_q  <= dout_d;
            dovld_q <= dovld_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            for (int c = 0; c < NCH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

    assign oid   = oid_q;
    assign dout  = dout_q;
    assign dovld = dovld_q;
    assign full  = full_q;
    assign ovf   = ovf_q;

`ifdef E1_TDM_MUX_OVF_STAT_EN
    logic [NCH-1:0] ovfsta_q, ovfsta_d;

    // Sticky overflow: a new drop in the same cycle as a clear keeps the bit set.
    always_comb begin
        ovfsta_d = ovf_d | (ovfsta_q & ~ovfclr);
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovfsta_q <= '0;
        end else begin
            ovfsta_q <= ovfsta_d;
        end
    end

    assign ovfsta = ovfsta_q;
`endif

endmodule

// File: tb/tb_e1_tdm_mux.sv
// Self-checking bench for e1_tdm_mux: queue-based reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_e1_tdm_mux;
    localparam int WID   = 8;
    localparam int NCH   = 21;
    localparam int CHB   = 5;
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic [NCH*WID-1:0] di = '0;
    logic [NCH-1:0]     vld = '0;
    logic [CHB-1:0]     oid;
    logic [WID-1:0]     dout;
    logic               dovld;
    logic [NCH-1:0]     full;
    logic [NCH-1:0]     ovf;
`ifdef E1_TDM_MUX_OVF_STAT_EN
    logic [NCH-1:0]     ovfclr = '0;
    logic [NCH-1:0]     ovfsta;
`endif

    e1_tdm_mux #(.WID(WID), .NCH(NCH), .CHB(CHB), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .di     (di),
        .vld    (vld),
`ifdef E1_TDM_MUX_OVF_STAT_EN
        .ovfclr (ovfclr),
        .ovfsta (ovfsta),
`endif
        .oid    (oid),
        .dout   (dout),
        .dovld  (dovld),
        .full   (full),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: one queue per channel, slot number as a plain integer.
    logic [WID-1:0] mq [NCH][$];
    int             mslot = 0;
    logic [CHB-1:0] e_oid = '0;
    logic [WID-1:0] e_do = '0;
    logic           e_dovld = 1'b0;
    logic [NCH-1:0] e_full = '0;
    logic [NCH-1:0] e_ovf = '0;
    logic [NCH-1:0] e_sta = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int c = 0; c < NCH; c++) mq[c].delete();
                mslot = 0; e_oid = '0; e_do = '0; e_dovld = 1'b0;
                e_full = '0; e_ovf = '0; e_sta = '0;
            end else begin
                int s;
                s = mslot;
                if (mq[s].size() > 0) begin
                    e_do = mq[s].pop_front();
                    e_dovld = 1'b1;
                end else begin
                    e_dovld = 1'b0;
                end
                e_oid = CHB'(s);
                for (int c = 0; c < NCH; c++) begin
                    e_ovf[c] = 1'b0;
                    if (vld[c]) begin
                        if (mq[c].size() < DEPTH) mq[c].push_back(di[c*WID +: WID]);
                        else e_ovf[c] = 1'b1;
                    end
                    e_full[c] = (mq[c].size() == DEPTH);
                end
`ifdef E1_TDM_MUX_OVF_STAT_EN
                e_sta = (e_sta & ~ovfclr) | e_ovf;
`endif
                mslot = (s + 1) % NCH;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("oid",   32'(oid),   32'(e_oid));
            chk("dovld", 32'(dovld), 32'(e_dovld));
            chk("do",    32'(dout),  32'(e_do));
            chk("full",  32'(full),  32'(e_full));
            chk("ovf",   32'(ovf),   32'(e_ovf));
`ifdef E1_TDM_MUX_OVF_STAT_EN
            chk("ovfsta", 32'(ovfsta), 32'(e_sta));
`endif
        end
    end

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        while (mslot != s && n < 2 * NCH) begin
            @(negedge clk);
            n++;
        end
        chk("slot_wait", 32'(mslot), 32'(s));
    endtask

    initial begin
        int got;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oid", 32'(oid), 32'd0);
        chk("rst_dovld", 32'(dovld), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rstn = 1'b1;

        // Idle: oid walks 0..20 and wraps, no valid output.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk("idle_oid", 32'(oid), 32'(i % NCH));
            chk("idle_dovld", 32'(dovld), 32'd0);
        end

        // Minimum latency on channel 3.
        wait_slot(2);
        vld[3] = 1'b1; di[3*WID +: WID] = 8'hA5;
        @(negedge clk);
        vld = '0;
        @(negedge clk);
        chk("lat_dovld", 32'(dovld), 32'd1);
        chk("lat_oid", 32'(oid), 32'd3);
        chk("lat_do", 32'(dout), 32'hA5);

        // Overflow on channel 7 with no intervening slot 7.
        wait_slot(8);
        for (int k = 1; k <= 5; k++) begin
            vld[7] = 1'b1; di[7*WID +: WID] = 8'(k);
            @(negedge clk);
            if (k == 4) chk("ch7_ovf_early", 32'(ovf[7]), 32'd0);
        end
        chk("ch7_ovf", 32'(ovf[7]), 32'd1);
        chk("ch7_full", 32'(full[7]), 32'd1);
        vld = '0;
        @(negedge clk);
        chk("ch7_ovf_once", 32'(ovf[7]), 32'd0);
        got = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (dovld && oid == CHB'(7)) begin
                got++;
                chk("ch7_order", 32'(dout), 32'(got));
            end
        end
        chk("ch7_count", 32'(got), 32'd4);

        // All channels written once per frame with byte = channel number.
        wait_slot(0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) di[c*WID +: WID] = 8'(c);
            vld = '1;
            for (int i = 0; i < NCH; i++) begin
                @(negedge clk);
                vld = '0;
                if (r >= 1) begin
                    chk("frame_dovld", 32'(dovld), 32'd1);
                    chk("frame_do", 32'(dout), 32'(oid));
                    chk("frame_ovf", 32'(ovf), 32'd0);
                end
            end
        end
        repeat (25) @(negedge clk);

        // Reset mid-stream with three bytes buffered on channel 0.
        wait_slot(1);
        for (int k = 0; k < 3; k++) begin
            vld[0] = 1'b1; di[0 +: WID] = 8'h11 * 8'(k + 1);
            @(negedge clk);
        end
        vld = '0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_oid", 32'(oid), 32'd0);
        chk("arst_do", 32'(dout), 32'd0);
        chk("arst_dovld", 32'(dovld), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_oid", 32'(oid), 32'd0);
        chk("post_dovld", 32'(dovld), 32'd0);
        got = 0;
        for (int i = 0; i < 2 * NCH; i++) begin
            @(negedge clk);
            if (dovld) got++;
        end
        chk("no_stale", 32'(got), 32'd0);

`ifdef E1_TDM_MUX_OVF_STAT_EN
        // Sticky overflow on channel 20.
        wait_slot(0);
        for (int k = 0; k < 5; k++) begin
            vld[20] = 1'b1; di[20*WID +: WID] = 8'(8'h40 + k);
            @(negedge clk);
        end
        vld = '0;
        chk("sta_set", 32'(ovfsta[20]), 32'd1);
        repeat (3) @(negedge clk);
        chk("sta_hold", 32'(ovfsta[20]), 32'd1);
        ovfclr[20] = 1'b1;
        @(negedge clk);
        ovfclr = '0;
        chk("sta_clr", 32'(ovfsta[20]), 32'd0);
        repeat (5) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/e1_tdm_mux.md
E1_TDM_MUX -- requirements
Module: e1_tdm_mux

Interface
REQ-001 SHALL have parameter WID, default 8, data width per channel.
REQ-002 SHALL have parameter NCH, default 21, channel count (2..32).
REQ-003 SHALL have parameter CHB, default 5, channel-ID width; 2^CHB >= NCH.
REQ-004 SHALL have parameter DEPTH, default 4, per-channel FIFO depth (power of 2, >= 2).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous reset, active low.
REQ-007 SHALL have port di  input  NCH*WID  channel data; channel c occupies bits [c*WID +: WID].
REQ-008 SHALL have port vld  input  NCH  per-channel write strobe, one byte per asserted cycle.
REQ-009 SHALL have port oid  output  CHB  channel ID of the current output slot.
REQ-010 SHALL have port do  output  WID  data out.
REQ-011 SHALL have port dovld  output  1  do/oid carry a valid byte.
REQ-012 SHALL have port full  output  NCH  per-channel FIFO full, registered.
REQ-013 SHALL have port ovf  output  NCH  one-cycle pulse per channel when a byte is dropped.

Function
REQ-014 SHALL keep one independent FIFO of DEPTH x WID per channel, with occupancy count width clog2(DEPTH)+1.
REQ-015 SHALL push di[c] into FIFO c on every edge where vld[c]=1 and the FIFO is not full, or is full and popped in the same cycle.
REQ-016 SHALL drop the byte and pulse ovf[c] for one cycle when vld[c]=1, FIFO c is full and there is no pop in that cycle; FIFO contents stay unchanged.
REQ-017 SHALL run slot counter chcnt 0..NCH-1, incrementing every cycle and wrapping NCH-1 -> 0.
REQ-018 SHALL pop FIFO chcnt in the cycle chcnt=c when it is non-empty; an empty FIFO is not popped and no underflow occurs.
REQ-019 SHALL register the slot result: on the next edge oid<=chcnt, dovld<=(pop), do<=popped byte when popped, else do holds its value.
REQ-020 SHALL give a latency of 2 cycles minimum: byte written at edge k to an empty FIFO c whose slot occurs at cycle k+1 appears on do after edge k+2.
REQ-021 SHALL preserve per-channel byte order; bytes of different channels never swap IDs.
REQ-022 SHALL let a simultaneous push and pop on an empty FIFO pop nothing; the byte is pushed and served at the next slot, NCH cycles later.
REQ-023 SHALL let a simultaneous push and pop on a non-empty FIFO leave the count unchanged.
REQ-024 SHALL output full[c]=1 when count[c]=DEPTH, registered.

Reset
REQ-025 SHALL, while rstn=0, asynchronously clear chcnt, all FIFO pointers and counts, oid=0, do=0, dovld=0, full=0 and ovf=0.
REQ-026 SHALL discard all buffered bytes on reset mid-operation; after rstn rises, the first slot served is channel 0.
REQ-027 SHALL not reset FIFO storage arrays; their contents are unobservable until written.

Configuration
REQ-028 SHALL support macro E1_TDM_MUX_OVF_STAT_EN; when defined, add input ovfclr (NCH) and output ovfsta (NCH) carrying sticky ovf, set by ovf and cleared by ovfclr[c]; set wins over clear in the same cycle; reset to 0.
REQ-029 SHALL omit ovfclr, ovfsta and their registers when E1_TDM_MUX_OVF_STAT_EN is undefined; all other behaviour is identical.

Verification
REQ-030 SHALL verify: reset release, no vld -> dovld=0 and oid cycles 0..20 then wraps to 0.
REQ-031 SHALL verify: vld[3]=1 with di ch3=8'hA5 one cycle before slot 3 -> dovld=1, oid=3, do=8'hA5 exactly 2 cycles after the write.
REQ-032 SHALL verify: 5 writes to ch7 (0x01..0x05) in 5 consecutive cycles with DEPTH=4, no pop -> full[7]=1, ovf[7] pulses once, and 0x01..0x04 are output in order on 4 successive ch7 slots.
REQ-033 SHALL verify: all 21 channels written every 21 cycles with byte equal to the channel number -> every slot has dovld=1 and do=oid, with no ovf.
REQ-034 SHALL verify: rstn pulsed low mid-stream with 3 bytes buffered in ch0 -> all outputs 0 immediately, and no stale byte appears after release.
REQ-035 SHALL verify: with E1_TDM_MUX_OVF_STAT_EN defined, overflow on ch20 -> ovfsta[20]=1 holds until ovfclr[20]=1, and clears one cycle later.
